sw_ref_read_arbiter: RTL and testbench

//  Shares the single DDR3 read port among NUM_REQ Smith-Waterman engines, one engine per query stream.

---
 rtl/sw_ref_read_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_sw_ref_read_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_ref_read_arbiter.sv
// sw_ref_read_arbiter
//  Shares one DDR3 read port among NUM_REQ Smith-Waterman engines. One
//  requester is picked round-robin, its read command is issued, and exactly
//  the requested number of beats is steered back to it before the next
//  arbitration. Only one transaction is in flight at a time.
//
//  Optional feature macro: SW_ARB_WDOG_EN
//    defined   : a DATA-state watchdog aborts a transaction after WDOG_CYCLES
//                cycles without a beat and sets the sticky wdog_err flag.
//    undefined : no watchdog, wdog_err tied low, DATA waits indefinitely.
//
//  Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_addr/req_beats    per-engine read requests (packed slices)
//   req_ready                       one-hot request accept (combinational)
//   mem_cmd_valid/ready/addr/beats  read command to the DDR3 port
//   mem_rd_valid/data, mem_rd_ready read beats from the DDR3 port
//   rsp_valid/data/last, rsp_ready  beats routed to the owning engine
//   busy                            a transaction is in progress
//   owner                           current or most recent grant index
//   wdog_err                        sticky watchdog timeout flag
module sw_ref_read_arbiter #(
  parameter int unsigned NUM_REQ     = 5,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned BEATS_W     = 8,
  parameter int unsigned WDOG_CYCLES = 1024,
  localparam int unsigned OWN_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*BEATS_W-1:0]   req_beats,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         mem_cmd_valid,
  input  logic                         mem_cmd_ready,
  output logic [ADDR_W-1:0]            mem_cmd_addr,
  output logic [BEATS_W-1:0]           mem_cmd_beats,
  input  logic                         mem_rd_valid,
  input  logic [DATA_W-1:0]            mem_rd_data,
  output logic                         mem_rd_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_last,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic                         busy,
  output logic [OWN_W-1:0]             owner,
  output logic                         wdog_err
);

  // One extra bit so last_owner + 1 + k never overflows before the wrap.
  localparam int unsigned SUM_W = OWN_W + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 2) begin : g_cfg_err
    $error("sw_ref_read_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [OWN_W-1:0]     owner_q, last_owner_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BEATS_W-1:0]   beats_q, cnt_q;

  logic                 any_req_c, grant_c;
  logic [OWN_W-1:0]     winner_c;
  logic [SUM_W-1:0]     cand_c;
  logic [ADDR_W-1:0]    win_addr_c;
  logic [BEATS_W-1:0]   win_beats_c;
  logic                 sel_rdy_c, beat_hs_c, last_hs_c, wdog_trip_c;

  // Round-robin pick: first valid requester scanning upward from last_owner+1.
  always_comb begin
    any_req_c = 1'b0;
    winner_c  = '0;
    cand_c    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand_c = SUM_W'(last_owner_q) + SUM_W'(k) + SUM_W'(1);
      if (cand_c >= SUM_W'(NUM_REQ)) cand_c = cand_c - SUM_W'(NUM_REQ);
      if (!any_req_c && req_valid[OWN_W'(cand_c)]) begin
        any_req_c = 1'b1;
        winner_c  = OWN_W'(cand_c);
      end
    end
  end

  // Payload of the winning requester.
  always_comb begin
    win_addr_c  = '0;
    win_beats_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (OWN_W'(i) == winner_c) begin
        win_addr_c  = req_addr[i*ADDR_W +: ADDR_W];
        win_beats_c = req_beats[i*BEATS_W +: BEATS_W];
      end
    end
  end

  // Owner's beat-accept; other engines' rsp_ready is ignored.
  always_comb begin
    sel_rdy_c = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (OWN_W'(i) == owner_q) sel_rdy_c = rsp_ready[i];
    end
  end

  // rst_n gating keeps req_ready low while reset is asserted.
  assign grant_c   = (state_q == ST_IDLE) && any_req_c && rst_n;
  assign beat_hs_c = (state_q == ST_DATA) && mem_rd_valid && sel_rdy_c;
  assign last_hs_c = beat_hs_c && (cnt_q == BEATS_W'(1));

`ifdef SW_ARB_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              wdog_err_q;

  // Trips on the edge where the idle count would reach WDOG_CYCLES.
  assign wdog_trip_c = (state_q == ST_DATA) && !beat_hs_c &&
                       (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

  // Idle-cycle counter, cleared outside DATA and on every beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (state_q != ST_DATA || beat_hs_c) wdog_cnt_q <= '0;
      else                                 wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
      if (wdog_trip_c) wdog_err_q <= 1'b1;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_trip_c = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; zero-length grants complete in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_c && win_beats_c != '0) state_d = ST_CMD;
      ST_CMD:  if (mem_cmd_ready)                state_d = ST_DATA;
      ST_DATA: if (last_hs_c || wdog_trip_c)     state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    req_ready     = '0;
    mem_cmd_valid = 1'b0;
    mem_rd_ready  = 1'b0;
    rsp_valid     = '0;
    rsp_last      = 1'b0;
    busy          = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
          if (grant_c && OWN_W'(i) == winner_c) req_ready[i] = 1'b1;
        end
      end
      ST_CMD: mem_cmd_valid = 1'b1;
      ST_DATA: begin
        mem_rd_ready = sel_rdy_c;
        rsp_last     = (cnt_q == BEATS_W'(1));
        for (int i = 0; i < int'(NUM_REQ); i++) begin
          rsp_valid[i] = mem_rd_valid && (OWN_W'(i) == owner_q);
        end
      end
      default: ;
    endcase
  end

  // Transaction capture, beat countdown and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= '0;
      last_owner_q <= OWN_W'(NUM_REQ - 1);
      addr_q       <= '0;
      beats_q      <= '0;
      cnt_q        <= '0;
    end else begin
      if (grant_c) begin
        owner_q <= winner_c;
        addr_q  <= win_addr_c;
        beats_q <= win_beats_c;
        if (win_beats_c == '0) last_owner_q <= winner_c;
      end
      if (state_q == ST_CMD && mem_cmd_ready) cnt_q <= beats_q;
      if (beat_hs_c)                          cnt_q <= cnt_q - BEATS_W'(1);
      if (last_hs_c || wdog_trip_c)           last_owner_q <= owner_q;
    end
  end

  assign mem_cmd_addr  = addr_q;
  assign mem_cmd_beats = beats_q;
  assign owner         = owner_q;
  assign rsp_data      = mem_rd_data;

endmodule

// File: tb/tb_sw_ref_read_arbiter.sv
// Scoreboard bench for sw_ref_read_arbiter: stimulus pushes expected grants,
// commands and response beats; a negedge monitor pops and compares them.
module tb_sw_ref_read_arbiter;
  localparam int unsigned N  = 5;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;
  localparam int unsigned BW = 8;
  localparam int unsigned OW = 3;

  typedef struct packed { logic [AW-1:0] addr; logic [BW-1:0] beats; } cmd_t;
  typedef struct packed { logic [2:0] eng; logic [DW-1:0] data; logic last; } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*BW-1:0]   req_beats;
  logic              mem_cmd_valid, mem_cmd_ready, mem_rd_valid, mem_rd_ready;
  logic [AW-1:0]     mem_cmd_addr;
  logic [BW-1:0]     mem_cmd_beats;
  logic [DW-1:0]     mem_rd_data, rsp_data;
  logic              rsp_last, busy, wdog_err;
  logic [OW-1:0]     owner;

  int checks = 0;
  int errors = 0;

  int   exp_grant[$];
  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];

  sw_ref_read_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BEATS_W(BW), .WDOG_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_beats(req_beats), .req_ready(req_ready),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_beats(mem_cmd_beats),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_rd_ready(mem_rd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
    .busy(busy), .owner(owner), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [N-1:0] onehot(input int e);
    return N'(1) << e;
  endfunction

  function automatic logic [DW-1:0] mkdata(input int e, input int k);
    return {96'h0, 16'hBEEF, 8'(e), 8'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_eng(input int e, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_addr[e*AW +: AW]  = a;
    req_beats[e*BW +: BW] = b;
  endtask

  task automatic reset_outputs_check();
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_cmd_valid", 128'(mem_cmd_valid), 128'(0));
    chk("rst_cmd_addr", 128'(mem_cmd_addr), 128'(0));
    chk("rst_cmd_beats", 128'(mem_cmd_beats), 128'(0));
    chk("rst_rd_ready", 128'(mem_rd_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_last", 128'(rsp_last), 128'(0));
    chk("rst_owner", 128'(owner), 128'(0));
    chk("rst_wdog", 128'(wdog_err), 128'(0));
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 after the grant edge.
  task automatic wait_grant(input int prev);
    int n;
    n = 0;
    @(negedge clk);
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_cmd_valid", 128'(mem_cmd_valid), 128'(0));
    if (prev >= 0) chk("idle_owner", 128'(owner), 128'(prev));
    while ((req_valid & req_ready) == '0 && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("grant_wait", 128'(n < 20), 128'(1));
    tick();
  endtask

  task automatic idle_check(input int prev);
    @(negedge clk);
    chk("end_busy", 128'(busy), 128'(0));
    chk("end_owner", 128'(owner), 128'(prev));
    tick();
  endtask

  // Command phase with optional stall, then beats with optional 1010 ready pattern.
  task automatic serve(input int eng, input int beats, input int stall, input bit toggle);
    int  k, c;
    logic rdy;
    for (int s = 0; s <= stall; s++) begin
      mem_cmd_ready = (s == stall);
      mem_rd_valid  = (s < stall);
      mem_rd_data   = {4{32'hDEAD_BEEF}};
      rsp_ready     = '1;
      @(negedge clk);
      chk("cmd_valid", 128'(mem_cmd_valid), 128'(1));
      if (s < stall) begin
        chk("rd_ready_outside_data", 128'(mem_rd_ready), 128'(0));
        chk("rsp_valid_outside_data", 128'(rsp_valid), 128'(0));
      end
      tick();
    end
    mem_cmd_ready = 1'b0;
    mem_rd_valid  = 1'b0;
    k = 0;
    c = 0;
    while (k < beats && c < 4 * beats + 8) begin
      rdy = toggle ? (c % 2 == 0) : 1'b1;
      rsp_ready      = '1;
      rsp_ready[eng] = rdy;
      mem_rd_valid   = 1'b1;
      mem_rd_data    = mkdata(eng, k);
      if (rdy) exp_rsp.push_back('{3'(eng), mkdata(eng, k), (k == beats - 1)});
      @(negedge clk);
      chk("rd_ready_mirror", 128'(mem_rd_ready), 128'(rdy));
      tick();
      if (rdy) k++;
      c++;
    end
    chk("beats_done", 128'(k), 128'(beats));
    mem_rd_valid = 1'b0;
    rsp_ready    = '0;
  endtask

  // Monitor: compares every handshake against the scoreboard queues.
  int           mon_g;
  cmd_t         mon_c;
  rsp_t         mon_r;
  logic         stall_q = 1'b0;
  logic [AW-1:0] st_addr;
  logic [BW-1:0] st_beats;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("cmd_hold_valid", 128'(mem_cmd_valid), 128'(1));
        chk("cmd_hold_addr", 128'(mem_cmd_addr), 128'(st_addr));
        chk("cmd_hold_beats", 128'(mem_cmd_beats), 128'(st_beats));
      end
      stall_q  = mem_cmd_valid && !mem_cmd_ready;
      st_addr  = mem_cmd_addr;
      st_beats = mem_cmd_beats;
      if ((req_valid & req_ready) != '0) begin
        if (exp_grant.size() == 0) chk("grant_unexpected", 128'(req_ready), 128'(0));
        else begin
          mon_g = exp_grant.pop_front();
          chk("grant", 128'(req_ready), 128'(onehot(mon_g)));
        end
      end
      if (mem_cmd_valid && mem_cmd_ready) begin
        if (exp_cmd.size() == 0) chk("cmd_unexpected", 128'(mem_cmd_addr), 128'(0));
        else begin
          mon_c = exp_cmd.pop_front();
          chk("cmd_addr", 128'(mem_cmd_addr), 128'(mon_c.addr));
          chk("cmd_beats", 128'(mem_cmd_beats), 128'(mon_c.beats));
        end
      end
      if (mem_rd_valid && mem_rd_ready) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
        else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_valid", 128'(rsp_valid), 128'(onehot(int'(mon_r.eng))));
          chk("rsp_data", rsp_data, mon_r.data);
          chk("rsp_last", 128'(rsp_last), 128'(mon_r.last));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_beats = '0;
    mem_cmd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0; rsp_ready = '0;
    for (int e = 0; e < int'(N); e++) set_eng(e, 32'(32'h1000 * (e + 1)), 8'd1);
    req_valid = '1;
    #12;
    reset_outputs_check();
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Round-robin with every engine requesting one beat.
    req_valid = '1;
    for (int t = 0; t < 6; t++) begin
      exp_grant.push_back(t % 5);
      exp_cmd.push_back('{32'(32'h1000 * ((t % 5) + 1)), 8'd1});
      wait_grant(t == 0 ? -1 : (t - 1) % 5);
      if (t == 5) req_valid = '0;
      serve(t % 5, 1, 0, 1'b0);
    end
    idle_check(0);

    // Single two-beat request from engine 1.
    set_eng(1, 32'h40, 8'd2);
    req_valid = 5'b00010;
    exp_grant.push_back(1);
    exp_cmd.push_back('{32'h40, 8'd2});
    wait_grant(0);
    req_valid = '0;
    serve(1, 2, 0, 1'b0);
    idle_check(1);

    // Command stall of 5 cycles and toggling beat-accept.
    set_eng(2, 32'h2000, 8'd3);
    req_valid = 5'b00100;
    exp_grant.push_back(2);
    exp_cmd.push_back('{32'h2000, 8'd3});
    wait_grant(1);
    req_valid = '0;
    serve(2, 3, 5, 1'b1);
    idle_check(2);

    // Zero-length request from engine 3, engine 4 wins next.
    set_eng(3, 32'h3000, 8'd0);
    set_eng(4, 32'h4400, 8'd1);
    req_valid = 5'b11000;
    exp_grant.push_back(3);
    wait_grant(2);
    exp_grant.push_back(4);
    exp_cmd.push_back('{32'h4400, 8'd1});
    wait_grant(3);
    req_valid = '0;
    serve(4, 1, 0, 1'b0);
    idle_check(4);

    // Reset in the middle of a four-beat transaction.
    set_eng(1, 32'h1100, 8'd1);
    req_valid = 5'b00010;
    exp_grant.push_back(1);
    exp_cmd.push_back('{32'h1100, 8'd1});
    wait_grant(4);
    req_valid = '0;
    serve(1, 1, 0, 1'b0);
    set_eng(2, 32'h2200, 8'd4);
    req_valid = 5'b00100;
    exp_grant.push_back(2);
    exp_cmd.push_back('{32'h2200, 8'd4});
    wait_grant(1);
    req_valid = '0;
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    chk("cmd_valid", 128'(mem_cmd_valid), 128'(1));
    tick();
    mem_cmd_ready = 1'b0;
    rsp_ready     = 5'b00100;
    mem_rd_valid  = 1'b1;
    mem_rd_data   = mkdata(2, 0);
    exp_rsp.push_back('{3'd2, mkdata(2, 0), 1'b0});
    tick();
    mem_rd_data = mkdata(2, 1);
    for (int e = 0; e < int'(N); e++) set_eng(e, 32'(32'h1000 * (e + 1)), 8'd1);
    req_valid = '1;
    #2;
    rst_n = 1'b0;
    #1;
    reset_outputs_check();
    tick();
    tick();
    mem_rd_valid = 1'b0;
    rsp_ready    = '0;
    exp_grant.delete();
    exp_cmd.delete();
    exp_rsp.delete();
    exp_grant.push_back(0);
    exp_cmd.push_back('{32'h1000, 8'd1});
    rst_n = 1'b1;
    wait_grant(0);
    serve(0, 1, 0, 1'b0);
    exp_grant.push_back(1);
    exp_cmd.push_back('{32'h2000, 8'd1});
    wait_grant(0);
    req_valid = '0;
    serve(1, 1, 0, 1'b0);
    idle_check(1);

`ifdef SW_ARB_WDOG_EN
    // No beats for 16 DATA cycles: abort, sticky error, next requester granted.
    set_eng(3, 32'h3300, 8'd2);
    set_eng(4, 32'h4400, 8'd1);
    req_valid = 5'b11000;
    exp_grant.push_back(3);
    exp_cmd.push_back('{32'h3300, 8'd2});
    wait_grant(1);
    req_valid = 5'b10000;
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    chk("cmd_valid", 128'(mem_cmd_valid), 128'(1));
    tick();
    mem_cmd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("wdog_wait_busy", 128'(busy), 128'(1));
      chk("wdog_wait_err", 128'(wdog_err), 128'(0));
      tick();
    end
    chk("wdog_err_set", 128'(wdog_err), 128'(1));
    exp_grant.push_back(4);
    exp_cmd.push_back('{32'h4400, 8'd1});
    wait_grant(3);
    req_valid = '0;
    serve(4, 1, 0, 1'b0);
    idle_check(4);
    chk("wdog_err_sticky", 128'(wdog_err), 128'(1));
`else
    chk("wdog_err_tied", 128'(wdog_err), 128'(0));
`endif

    chk("sb_drained", 128'(exp_grant.size() + exp_cmd.size() + exp_rsp.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
